// File: rtl/hub75_capture.sv
// HUB75 receive-side loopback: rebuilds shifted lines into tagged 32-bit records for a capture RAM.
// Data word 1 cycle after its 5th pixel, marker 1-2 cycles after latch; no backpressure, stops on full unless WRAP.
module hub75_capture #(
  parameter int ADDR_W = 15,
  parameter bit WRAP   = 1'b0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  input  logic [8:0]        pixels_per_row,
  input  logic              led_clk,
  input  logic              latch_enable,
  input  logic              plane_oe,
  input  logic [4:0]        ABCDE,
  input  logic              r0,
  input  logic              g0,
  input  logic              b0,
  input  logic              r1,
  input  logic              g1,
  input  logic              b1,
  output logic              cap_wr_en,
  output logic [ADDR_W-1:0] cap_wr_addr,
  output logic [31:0]       cap_wr_data,
  output logic              cap_full,
  output logic [15:0]       cap_lines,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_CAPTURE, S_FLUSH, S_MARK, S_FULL
  } state_t;

  state_t              state_q, state_d;
  logic                led_prev_q, lat_prev_q, en_prev_q;
  logic [29:0]         word_q, word_d;
  logic [2:0]          slot_q, slot_d;
  logic [8:0]          cnt_q, cnt_d;
  logic [4:0]          row_q, row_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [31:0]         wr_data_q, wr_data_d;
  logic                full_q, full_d;
  logic [15:0]         lines_q, lines_d;

  logic                led_rise, lat_rise, en_rise;
  logic [5:0]          pix;
  logic [29:0]         sh_word;
  logic [8:0]          sh_cnt;
  logic                sh_done;
  logic                do_wr;
  logic [31:0]         wdat;
  logic                unused_oe;

  assign unused_oe = plane_oe;
  assign led_rise  = led_clk & ~led_prev_q;
  assign lat_rise  = latch_enable & ~lat_prev_q;
  assign en_rise   = enable & ~en_prev_q;
  assign pix       = {b1, g1, r1, b0, g0, r0};

  function automatic logic [31:0] marker(input logic [8:0] c, input logic [4:0] r,
                                         input logic [8:0] ppr);
    return {2'b10, 15'd0, (c != ppr), r, c};
  endfunction

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    slot_d    = slot_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    ptr_d     = ptr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    full_d    = full_q;
    lines_d   = lines_q;
    do_wr     = 1'b0;
    wdat      = '0;

    sh_word = word_q;
    for (int i = 0; i < 5; i++) begin
      if (slot_q == 3'(i)) sh_word[6*i +: 6] = pix;
    end
    sh_cnt  = (cnt_q == 9'h1ff) ? cnt_q : cnt_q + 9'd1;
    sh_done = (slot_q == 3'd4);

    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (en_rise) begin
            state_d   = S_ARMED;
            ptr_d     = '0;
            wr_addr_d = '0;
            full_d    = 1'b0;
            lines_d   = '0;
            word_d    = '0;
            slot_d    = '0;
            cnt_d     = '0;
          end
        end
        S_ARMED: begin
          if (lat_rise) begin
            word_d  = '0;
            slot_d  = '0;
            cnt_d   = '0;
            state_d = S_CAPTURE;
          end
        end
        S_CAPTURE, S_MARK: begin
          if (state_q == S_MARK) state_d = S_CAPTURE;
          if (led_rise) begin
            cnt_d = sh_cnt;
            if (sh_done) begin
              do_wr  = 1'b1;
              wdat   = {2'b01, sh_word};
              word_d = '0;
              slot_d = '0;
            end else begin
              word_d = sh_word;
              slot_d = slot_q + 3'd1;
            end
          end
          // A pixel shifted in the latch cycle has already been folded into word_d/cnt_d.
          if (lat_rise) begin
            row_d = ABCDE;
            if (led_rise && sh_done) begin
              state_d = S_FLUSH;
            end else if (slot_d != 3'd0) begin
              do_wr   = 1'b1;
              wdat    = {2'b01, word_d};
              word_d  = '0;
              slot_d  = '0;
              state_d = S_FLUSH;
            end else begin
              do_wr   = 1'b1;
              wdat    = marker(cnt_d, ABCDE, pixels_per_row);
              lines_d = lines_q + 16'd1;
              cnt_d   = '0;
              state_d = S_MARK;
            end
          end
        end
        S_FLUSH: begin
          do_wr   = 1'b1;
          wdat    = marker(cnt_q, row_q, pixels_per_row);
          lines_d = lines_q + 16'd1;
          state_d = S_MARK;
          if (led_rise) begin
            word_d = sh_word;
            slot_d = 3'd1;
            cnt_d  = 9'd1;
          end else begin
            cnt_d  = '0;
          end
        end
        S_FULL:  state_d = S_FULL;
        default: state_d = S_IDLE;
      endcase
    end

    if (do_wr) begin
      wr_en_d   = 1'b1;
      wr_data_d = wdat;
      wr_addr_d = ptr_q;
      ptr_d     = ptr_q + 1'b1;
      if (!WRAP && (&ptr_q)) begin
        full_d  = 1'b1;
        state_d = S_FULL;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      led_prev_q <= 1'b0;
      lat_prev_q <= 1'b0;
      en_prev_q  <= 1'b0;
      word_q     <= '0;
      slot_q     <= '0;
      cnt_q      <= '0;
      row_q      <= '0;
      ptr_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      full_q     <= 1'b0;
      lines_q    <= '0;
    end else begin
      state_q    <= state_d;
      led_prev_q <= led_clk;
      lat_prev_q <= latch_enable;
      en_prev_q  <= enable;
      word_q     <= word_d;
      slot_q     <= slot_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      ptr_q      <= ptr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      full_q     <= full_d;
      lines_q    <= lines_d;
    end
  end

  assign cap_wr_en   = wr_en_q;
  assign cap_wr_addr = wr_addr_q;
  assign cap_wr_data = wr_data_q;
  assign cap_full    = full_q;
  assign cap_lines   = lines_q;
  assign busy        = (state_q == S_ARMED) || (state_q == S_CAPTURE) ||
                       (state_q == S_FLUSH) || (state_q == S_MARK);

endmodule

// File: tb/tb_hub75_capture.sv
// Scoreboard bench for hub75_capture: a line-level model queues expected records, monitors pop on each write.
module tb_hub75_capture;

  logic        clk;
  logic        resetn;
  logic        enable;
  logic [8:0]  ppr;
  logic        led_clk, latch_enable, plane_oe;
  logic [4:0]  ABCDE;
  logic        r0, g0, b0, r1, g1, b1;

  logic        m_en, m_full, m_busy;
  logic [14:0] m_addr_o;
  logic [31:0] m_data;
  logic [15:0] m_lines_o;
  logic        nw_en, nw_full, nw_busy;
  logic [2:0]  nw_addr;
  logic [31:0] nw_data;
  logic [15:0] nw_lines;
  logic        w_en, w_full, w_busy;
  logic [2:0]  w_addr;
  logic [31:0] w_data;
  logic [15:0] w_lines;

  hub75_capture dut (
    .clk(clk), .resetn(resetn), .enable(enable), .pixels_per_row(ppr),
    .led_clk(led_clk), .latch_enable(latch_enable), .plane_oe(plane_oe), .ABCDE(ABCDE),
    .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .cap_wr_en(m_en), .cap_wr_addr(m_addr_o), .cap_wr_data(m_data),
    .cap_full(m_full), .cap_lines(m_lines_o), .busy(m_busy)
  );

  hub75_capture #(.ADDR_W(3), .WRAP(1'b0)) u_nw (
    .clk(clk), .resetn(resetn), .enable(enable), .pixels_per_row(ppr),
    .led_clk(led_clk), .latch_enable(latch_enable), .plane_oe(plane_oe), .ABCDE(ABCDE),
    .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .cap_wr_en(nw_en), .cap_wr_addr(nw_addr), .cap_wr_data(nw_data),
    .cap_full(nw_full), .cap_lines(nw_lines), .busy(nw_busy)
  );

  hub75_capture #(.ADDR_W(3), .WRAP(1'b1)) u_w (
    .clk(clk), .resetn(resetn), .enable(enable), .pixels_per_row(ppr),
    .led_clk(led_clk), .latch_enable(latch_enable), .plane_oe(plane_oe), .ABCDE(ABCDE),
    .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .cap_wr_en(w_en), .cap_wr_addr(w_addr), .cap_wr_data(w_data),
    .cap_full(w_full), .cap_lines(w_lines), .busy(w_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [14:0] addr;
    logic [31:0] data;
  } rec_t;

  rec_t q_main[$];
  rec_t q_nw[$];
  rec_t q_w[$];
  rec_t e_m, e_nw, e_w;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Line-level reference model
  bit          sm_on = 0;
  bit          m_arm = 0;
  bit          m_cap = 0;
  int          m_cnt = 0;
  int          m_slot = 0;
  logic [29:0] m_word = '0;
  logic [14:0] m_addr = '0;
  int          m_lines = 0;
  int          a_nw = 0;
  bit          f_nw = 0;
  int          a_w = 0;

  int          samp_cyc = 0;
  int          last_data_cyc = -1;
  int          last_mark_cyc = -1;
  logic [31:0] last_mark = '0;

  function automatic void push_rec(input logic [31:0] d);
    q_main.push_back({m_addr, d});
    m_addr = m_addr + 15'd1;
    if (sm_on) begin
      if (!f_nw) begin
        q_nw.push_back({15'(a_nw), d});
        if (a_nw == 7) f_nw = 1;
        a_nw++;
      end
      q_w.push_back({15'(a_w), d});
      a_w = (a_w + 1) % 8;
    end
  endfunction

  function automatic void m_clear();
    m_cnt = 0; m_slot = 0; m_word = '0;
  endfunction

  function automatic void m_pix(input logic [5:0] p);
    if (!m_cap) return;
    m_word[m_slot*6 +: 6] = p;
    m_slot++;
    if (m_cnt < 511) m_cnt++;
    if (m_slot == 5) begin
      push_rec({2'b01, m_word});
      m_word = '0;
      m_slot = 0;
    end
  endfunction

  function automatic void m_latch(input logic [4:0] row);
    logic [8:0] c;
    if (m_arm && !m_cap) begin
      m_cap = 1;
      m_clear();
    end else if (m_cap) begin
      if (m_slot != 0) push_rec({2'b01, m_word});
      c = 9'(m_cnt);
      push_rec({2'b10, 15'd0, (c != ppr), row, c});
      m_lines++;
      m_clear();
    end
  endfunction

  // Monitors: compare every write strobe against the head of its queue
  always @(negedge clk) begin
    if (resetn && m_en) begin
      if (q_main.size() == 0) chk("main_unexpected_wr", 32'(m_en), 32'd0);
      else begin
        e_m = q_main.pop_front();
        chk("main_addr", 32'(m_addr_o), 32'(e_m.addr));
        chk("main_data", m_data, e_m.data);
      end
      if (m_data[31:30] == 2'b10) begin
        last_mark = m_data;
        last_mark_cyc = cyc;
      end else begin
        last_data_cyc = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (resetn && sm_on && nw_en) begin
      if (q_nw.size() == 0) chk("nw_unexpected_wr", 32'(nw_en), 32'd0);
      else begin
        e_nw = q_nw.pop_front();
        chk("nw_addr", 32'(nw_addr), 32'(e_nw.addr));
        chk("nw_data", nw_data, e_nw.data);
      end
    end
  end

  always @(negedge clk) begin
    if (resetn && sm_on && w_en) begin
      if (q_w.size() == 0) chk("w_unexpected_wr", 32'(w_en), 32'd0);
      else begin
        e_w = q_w.pop_front();
        chk("w_addr", 32'(w_addr), 32'(e_w.addr));
        chk("w_data", w_data, e_w.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input logic [5:0] p);
    {b1, g1, r1, b0, g0, r0} = p;
    m_pix(p);
    led_clk = 1'b1;
    step();
    samp_cyc = cyc;
    led_clk = 1'b0;
    step();
  endtask

  task automatic latch(input logic [4:0] row);
    ABCDE = row;
    m_latch(row);
    latch_enable = 1'b1;
    step();
    samp_cyc = cyc;
    latch_enable = 1'b0;
    repeat (3) step();
  endtask

  task automatic pix_latch(input logic [5:0] p, input logic [4:0] row);
    {b1, g1, r1, b0, g0, r0} = p;
    ABCDE = row;
    m_pix(p);
    m_latch(row);
    led_clk = 1'b1;
    latch_enable = 1'b1;
    step();
    samp_cyc = cyc;
    led_clk = 1'b0;
    latch_enable = 1'b0;
    repeat (3) step();
  endtask

  task automatic en_toggle();
    enable = 1'b0;
    m_cap = 0; m_arm = 0;
    repeat (2) step();
    enable = 1'b1;
    m_arm = 1; m_addr = '0; m_lines = 0;
    a_nw = 0; f_nw = 0; a_w = 0;
    step();
  endtask

  task automatic chk_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_wr_en"}, 32'(m_en), 32'd0);
    chk({tag, "_wr_addr"}, 32'(m_addr_o), 32'd0);
    chk({tag, "_wr_data"}, m_data, 32'd0);
    chk({tag, "_full"}, 32'(m_full), 32'd0);
    chk({tag, "_lines"}, 32'(m_lines_o), 32'd0);
    chk({tag, "_busy"}, 32'(m_busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d expected < 50000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; enable = 1'b0; ppr = 9'd16;
    led_clk = 1'b0; latch_enable = 1'b0; plane_oe = 1'b0; ABCDE = '0;
    {b1, g1, r1, b0, g0, r0} = '0;
    repeat (3) step();
    chk_reset_outputs("rst");
    resetn = 1'b1;
    step();

    // Arm; pixels before the first latch must be dropped
    enable = 1'b1;
    m_arm = 1; m_addr = '0; m_lines = 0;
    step();
    @(negedge clk);
    chk("busy_armed", 32'(m_busy), 32'd1);
    for (int i = 0; i < 3; i++) pixel(6'h15);
    latch(5'd3);
    for (int i = 0; i < 16; i++) pixel(6'h01);
    latch(5'd3);
    chk("mark_first", last_mark, 32'h80000610);
    chk("lines_1", 32'(m_lines_o), 32'd1);
    chk("drain_1", 32'(q_main.size()), 32'd0);

    // 17 random pixels: count mismatch
    for (int i = 0; i < 17; i++) pixel(6'($urandom_range(0, 63)));
    latch(5'd3);
    chk("mark17", last_mark, 32'h80004611);

    // 5 pixels: exactly one data word, marker with no partial ahead of it
    for (int i = 0; i < 5; i++) pixel(6'($urandom_range(0, 63)));
    chk("lat_pix5", 32'(last_data_cyc), 32'(samp_cyc));
    latch(5'd5);
    chk("lat_mark_nopart", 32'(last_mark_cyc), 32'(samp_cyc));
    chk("mark5", last_mark, 32'h80004A05);

    // Latch coincident with the 16th led_clk rise
    for (int i = 0; i < 15; i++) pixel(6'(i * 7 + 3));
    pix_latch(6'h2A, 5'd7);
    chk("lat_part", 32'(last_data_cyc), 32'(samp_cyc));
    chk("lat_mark_part", 32'(last_mark_cyc), 32'(samp_cyc + 1));
    chk("mark16_same", last_mark, 32'h80000E10);
    chk("lines_4", 32'(m_lines_o), 32'(m_lines));
    chk("drain_2", 32'(q_main.size()), 32'd0);

    // Reset during CAPTURE
    for (int i = 0; i < 3; i++) pixel(6'h3F);
    resetn = 1'b0;
    enable = 1'b0;
    m_cap = 0; m_arm = 0; m_lines = 0;
    chk_reset_outputs("midrst");
    step();
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) pixel(6'h11);
    latch(5'd1);
    enable = 1'b1;
    m_arm = 1; m_addr = '0; m_lines = 0;
    step();
    for (int i = 0; i < 2; i++) pixel(6'h22);
    latch(5'd1);
    for (int i = 0; i < 16; i++) pixel(6'($urandom_range(0, 63)));
    latch(5'd1);
    chk("lines_after_rst", 32'(m_lines_o), 32'd1);
    chk("drain_3", 32'(q_main.size()), 32'd0);

    // Small buffers: stop at full vs wrap
    en_toggle();
    sm_on = 1;
    latch(5'd2);
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 16; i++) pixel(6'(l * 16 + i));
      latch(5'd2);
    end
    chk("nw_full", 32'(nw_full), 32'd1);
    chk("nw_busy", 32'(nw_busy), 32'd0);
    chk("w_full", 32'(w_full), 32'd0);
    chk("main_full", 32'(m_full), 32'd0);
    chk("lines_3", 32'(m_lines_o), 32'd3);
    chk("drain_main", 32'(q_main.size()), 32'd0);
    chk("drain_nw", 32'(q_nw.size()), 32'd0);
    chk("drain_w", 32'(q_w.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
